// File: rtl/dec_level_arbiter.sv
// -----------------------------------------------------------------------------
// dec_level_arbiter
//   Round-robin arbiter that shares one sym4 8-tap fp32 filter pipeline among
//   N_REQ decomposition levels. Each level offers a two-sample pair. One pair
//   per cycle is issued into the shared pipeline together with a level tag.
//   The tag rides a fixed-latency shadow pipe alongside the filter. When the
//   result comes back, the tag at the tail of the shadow pipe selects the
//   level that receives it.
//
// Ports
//   i_clk_312_5      clock
//   i_rstn           async active-low reset
//   i_cfg_en         per-level enable; disabled levels are never granted
//   i_req_valid      per-level pair ready
//   i_req_x0/x1      per-level even/odd sample, level i at [i*DW +: DW]
//   o_req_ready      one-hot grant (transfer = valid & ready)
//   o_issue_valid    pair valid towards the shared pipeline
//   o_issue_x0/x1    issued even/odd sample
//   o_issue_tag      level index of the issued pair
//   i_pipe_res_valid result valid from the shared pipeline
//   i_pipe_res_data  filter result
//   o_res_valid      one-hot result strobe to the owning level
//   o_res_data       result sample
//   o_err_sticky     result/tag misalignment seen; cleared only by reset
// -----------------------------------------------------------------------------

// Per-level slice: eligibility and the registered result strobe.
module dec_level_lane #(
  parameter int TW   = 2,
  parameter int LANE = 0
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_req_valid,
  input  logic          i_cfg_en,
  input  logic          i_res_hit,
  input  logic [TW-1:0] i_res_tag,
  output logic          o_elig,
  output logic          o_res_valid
);
  logic r_res_valid;

  assign o_elig      = i_req_valid & i_cfg_en;
  assign o_res_valid = r_res_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_res_valid <= 1'b0;
    else         r_res_valid <= i_res_hit && (i_res_tag == TW'(LANE));
  end
endmodule

module dec_level_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 32,
  parameter  int PIPE_LAT = 12,
  localparam int TW       = $clog2(N_REQ)
) (
  input  logic                i_clk_312_5,
  input  logic                i_rstn,
  input  logic [N_REQ-1:0]    i_cfg_en,
  input  logic [N_REQ-1:0]    i_req_valid,
  input  logic [N_REQ*DW-1:0] i_req_x0,
  input  logic [N_REQ*DW-1:0] i_req_x1,
  output logic [N_REQ-1:0]    o_req_ready,
  output logic                o_issue_valid,
  output logic [DW-1:0]       o_issue_x0,
  output logic [DW-1:0]       o_issue_x1,
  output logic [TW-1:0]       o_issue_tag,
  input  logic                i_pipe_res_valid,
  input  logic [DW-1:0]       i_pipe_res_data,
  output logic [N_REQ-1:0]    o_res_valid,
  output logic [DW-1:0]       o_res_data,
  output logic                o_err_sticky
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_grant;
  logic [TW-1:0]    w_gidx;
  logic             w_found;
  logic             w_xfer;
  logic [TW-1:0]    w_ptr_nxt;
  logic [DW-1:0]    w_sel_x0;
  logic [DW-1:0]    w_sel_x1;
  logic [TW-1:0]    r_ptr;

  // Scan eligible levels starting at the pointer, wrapping modulo N_REQ.
  // N_REQ need not be a power of two, so the wrap is explicit.
  always_comb begin
    int            idx;
    logic [TW-1:0] idx_t;
    w_found = 1'b0;
    w_gidx  = '0;
    idx     = 0;
    idx_t   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(r_ptr) + k) % N_REQ;
      idx_t = TW'(idx);
      if (!w_found && w_elig[idx_t]) begin
        w_found = 1'b1;
        w_gidx  = idx_t;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  // Ready is gated by reset so that no level sees a grant while held in reset.
  assign o_req_ready = w_grant & {N_REQ{i_rstn}};
  assign w_xfer      = |o_req_ready;
  assign w_ptr_nxt   = (w_gidx == TW'(N_REQ - 1)) ? '0 : w_gidx + TW'(1);
  assign w_sel_x0    = i_req_x0[int'(w_gidx)*DW +: DW];
  assign w_sel_x1    = i_req_x1[int'(w_gidx)*DW +: DW];

  // ---------------------------------------------------------------------------
  // Issue register: data/tag hold their last values when nothing is issued.
  // ---------------------------------------------------------------------------
  logic          r_issue_valid;
  logic [DW-1:0] r_issue_x0;
  logic [DW-1:0] r_issue_x1;
  logic [TW-1:0] r_issue_tag;

  always_ff @(posedge i_clk_312_5 or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_x0    <= '0;
      r_issue_x1    <= '0;
      r_issue_tag   <= '0;
    end else begin
      r_issue_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr       <= w_ptr_nxt;
        r_issue_x0  <= w_sel_x0;
        r_issue_x1  <= w_sel_x1;
        r_issue_tag <= w_gidx;
      end
    end
  end

  assign o_issue_valid = r_issue_valid;
  assign o_issue_x0    = r_issue_x0;
  assign o_issue_x1    = r_issue_x1;
  assign o_issue_tag   = r_issue_tag;

  // ---------------------------------------------------------------------------
  // Shadow pipe: PIPE_LAT stages of {valid, tag}. An issue visible in cycle T
  // reaches the tail in cycle T+PIPE_LAT, the same cycle as its filter result.
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0]         r_sh_vld;
  logic [PIPE_LAT-1:0][TW-1:0] r_sh_tag;
  logic                        w_tail_vld;
  logic [TW-1:0]               w_tail_tag;

  always_ff @(posedge i_clk_312_5 or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sh_vld <= '0;
      r_sh_tag <= '0;
    end else begin
      r_sh_vld <= {r_sh_vld[PIPE_LAT-2:0], r_issue_valid};
      r_sh_tag <= {r_sh_tag[PIPE_LAT-2:0], r_issue_tag};
    end
  end

  assign w_tail_vld = r_sh_vld[PIPE_LAT-1];
  assign w_tail_tag = r_sh_tag[PIPE_LAT-1];

  // ---------------------------------------------------------------------------
  // Result routing and misalignment detection. A result without a tail entry
  // (orphan) is dropped; a tail entry without a result produces no strobe.
  // ---------------------------------------------------------------------------
  logic          w_hit;
  logic [DW-1:0] r_res_data;
  logic          r_err;

  assign w_hit = i_pipe_res_valid & w_tail_vld;

  always_ff @(posedge i_clk_312_5 or negedge i_rstn) begin
    if (!i_rstn) begin
      r_res_data <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hit) r_res_data <= i_pipe_res_data;
      if (i_pipe_res_valid != w_tail_vld) r_err <= 1'b1;
    end
  end

  assign o_res_data   = r_res_data;
  assign o_err_sticky = r_err;

  // ---------------------------------------------------------------------------
  // Per-level slices
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    dec_level_lane #(
      .TW   (TW),
      .LANE (i)
    ) u_lane (
      .i_clk       (i_clk_312_5),
      .i_rstn      (i_rstn),
      .i_req_valid (i_req_valid[i]),
      .i_cfg_en    (i_cfg_en[i]),
      .i_res_hit   (w_hit),
      .i_res_tag   (w_tail_tag),
      .o_elig      (w_elig[i]),
      .o_res_valid (o_res_valid[i])
    );
  end

endmodule

// File: tb/tb_dec_level_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dec_level_arbiter
//   Self-checking bench for dec_level_arbiter. The bench also plays the shared
//   filter pipeline: every issued pair is returned exactly PIPE_LAT cycles
//   later with a fresh result value. Expectations come from a cycle model that
//   keeps the round-robin pointer as an integer and in-flight pairs in a queue.
// -----------------------------------------------------------------------------
module tb_dec_level_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PL = 12;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N-1:0]         cfg_en;
  logic [N-1:0]         req_valid;
  logic [N-1:0][DW-1:0] tb_x0;
  logic [N-1:0][DW-1:0] tb_x1;
  logic [N-1:0]         req_ready;
  logic                 issue_valid;
  logic [DW-1:0]        issue_x0;
  logic [DW-1:0]        issue_x1;
  logic [1:0]           issue_tag;
  logic                 pipe_res_valid;
  logic [DW-1:0]        pipe_res_data;
  logic [N-1:0]         res_valid;
  logic [DW-1:0]        res_data;
  logic                 err_sticky;

  always #5 clk = ~clk;

  dec_level_arbiter #(.N_REQ(N), .DW(DW), .PIPE_LAT(PL)) dut (
    .i_clk_312_5      (clk),
    .i_rstn           (rstn),
    .i_cfg_en         (cfg_en),
    .i_req_valid      (req_valid),
    .i_req_x0         (tb_x0),
    .i_req_x1         (tb_x1),
    .o_req_ready      (req_ready),
    .o_issue_valid    (issue_valid),
    .o_issue_x0       (issue_x0),
    .o_issue_x1       (issue_x1),
    .o_issue_tag      (issue_tag),
    .i_pipe_res_valid (pipe_res_valid),
    .i_pipe_res_data  (pipe_res_data),
    .o_res_valid      (res_valid),
    .o_res_data       (res_data),
    .o_err_sticky     (err_sticky)
  );

  // ---------------- reference model state ----------------
  typedef struct { int due; logic [1:0] tag; } pend_t;
  pend_t pq[$];

  int            m_ptr;
  int            cyc;
  int            errors;
  int            checks;
  bit            inject;
  bit            force_pd;
  logic [DW-1:0] forced_pd;

  logic [N-1:0]  exp_ready;
  logic          exp_iv,  nxt_iv;
  logic [DW-1:0] exp_ix0, nxt_ix0, exp_ix1, nxt_ix1;
  logic [1:0]    exp_itag, nxt_itag;
  logic [N-1:0]  exp_rv,  nxt_rv;
  logic [DW-1:0] exp_rd,  nxt_rd;
  logic          exp_err, nxt_err;

  // Apply level inputs and predict the grant plus next-cycle issue outputs.
  task automatic drive_and_predict(input logic [N-1:0] vld, input logic [N-1:0] en,
                                   input bit randd);
    int g;
    if (randd) for (int i = 0; i < N; i++) begin
      tb_x0[i] = $urandom;
      tb_x1[i] = $urandom;
    end
    req_valid = vld;
    cfg_en    = en;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && vld[(m_ptr + k) % N] && en[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      nxt_iv   = 1'b1;
      nxt_ix0  = tb_x0[g];
      nxt_ix1  = tb_x1[g];
      nxt_itag = 2'(g);
      m_ptr    = (g + 1) % N;
    end else begin
      nxt_iv = 1'b0;
    end
  endtask

  // One clock cycle: advance model, play the filter pipeline, drive requests.
  task automatic tick(input logic [N-1:0] vld, input logic [N-1:0] en, input bit randd);
    logic [DW-1:0] pd;
    @(posedge clk); #1;
    cyc++;
    exp_iv = nxt_iv; exp_ix0 = nxt_ix0; exp_ix1 = nxt_ix1; exp_itag = nxt_itag;
    exp_rv = nxt_rv; exp_rd = nxt_rd;   exp_err = nxt_err;
    if (exp_iv) pq.push_back('{due: cyc + PL, tag: exp_itag});
    nxt_rv = '0;
    pipe_res_valid = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pd = force_pd ? forced_pd : $urandom;
      pipe_res_valid = 1'b1;
      pipe_res_data  = pd;
      nxt_rv = 4'(1) << pq[0].tag;
      nxt_rd = pd;
      void'(pq.pop_front());
    end else if (inject) begin
      pipe_res_valid = 1'b1;
      pipe_res_data  = $urandom;
      nxt_err = 1'b1;
    end
    drive_and_predict(vld, en, randd);
  endtask

  task automatic assert_reset(input logic [N-1:0] vld, input logic [N-1:0] en);
    @(posedge clk); #1;
    rstn = 1'b0;
    pipe_res_valid = 1'b0;
    inject = 1'b0;
    req_valid = vld;
    cfg_en = en;
    pq.delete();
    m_ptr = 0;
    exp_iv = 0; exp_ix0 = '0; exp_ix1 = '0; exp_itag = '0; exp_rv = '0; exp_rd = '0; exp_err = 0;
    nxt_iv = 0; nxt_ix0 = '0; nxt_ix1 = '0; nxt_itag = '0; nxt_rv = '0; nxt_rd = '0; nxt_err = 0;
    exp_ready = '0;
    #1;
  endtask

  task automatic release_reset(input logic [N-1:0] vld, input logic [N-1:0] en);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive_and_predict(vld, en, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset(4'hF, 4'hF);
    @(posedge clk); @(negedge clk);
    checks++; if (req_ready   !== 4'b0)  begin errors++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++; if (issue_valid !== 1'b0)  begin errors++; $display("FAIL rst_issue_valid got=%b exp=0", issue_valid); end
    checks++; if (issue_x0 !== 32'h0 || issue_x1 !== 32'h0 || issue_tag !== 2'd0)
      begin errors++; $display("FAIL rst_issue_data got=%h/%h/%0d exp=0", issue_x0, issue_x1, issue_tag); end
    checks++; if (res_valid !== 4'b0 || res_data !== 32'h0)
      begin errors++; $display("FAIL rst_res got=%b/%h exp=0", res_valid, res_data); end
    checks++; if (err_sticky !== 1'b0)   begin errors++; $display("FAIL rst_err got=%b exp=0", err_sticky); end
    release_reset(4'hF, 4'hF);
    checks++; if (req_ready !== 4'b0001 || req_ready !== exp_ready)
      begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq;
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      tick(4'hF, 4'hF, 1'b1);
      seq = 4'(1) << (k % 4);
      checks++; if (req_ready !== seq || req_ready !== exp_ready)
        begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, seq); end
      if (k > 0) begin
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 2'((k - 1) % 4))
          begin errors++; $display("FAIL rr_issue k=%0d got=%b/%0d exp=1/%0d", k, issue_valid, issue_tag, (k - 1) % 4); end
        checks++; if (issue_x0 !== exp_ix0 || issue_x1 !== exp_ix1)
          begin errors++; $display("FAIL rr_issue_data k=%0d got=%h/%h exp=%h/%h", k, issue_x0, issue_x1, exp_ix0, exp_ix1); end
      end
    end
    for (int k = 0; k < PL + 3; k++) begin
      tick(4'h0, 4'hF, 1'b1);
      checks++; if (issue_valid !== exp_iv || issue_tag !== exp_itag)
        begin errors++; $display("FAIL rr_drain_issue got=%b/%0d exp=%b/%0d", issue_valid, issue_tag, exp_iv, exp_itag); end
      checks++; if (res_valid !== exp_rv || res_data !== exp_rd)
        begin errors++; $display("FAIL rr_res got=%b/%h exp=%b/%h", res_valid, res_data, exp_rv, exp_rd); end
    end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rr_err got=%b exp=0", err_sticky); end
  endtask

  task automatic test_single_level();
    int t0;
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    tb_x0[2] = 32'h3f800000;
    tb_x1[2] = 32'h40000000;
    force_pd = 1'b1;
    forced_pd = 32'h3e800000;
    tick(4'b0100, 4'hF, 1'b0);
    t0 = cyc;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    tick(4'h0, 4'hF, 1'b0);
    checks++; if (issue_valid !== 1'b1 || issue_tag !== 2'd2)
      begin errors++; $display("FAIL single_issue got=%b/%0d exp=1/2", issue_valid, issue_tag); end
    checks++; if (issue_x0 !== 32'h3f800000 || issue_x1 !== 32'h40000000)
      begin errors++; $display("FAIL single_issue_data got=%h/%h exp=3f800000/40000000", issue_x0, issue_x1); end
    for (int k = 0; k < PL + 4; k++) begin
      tick(4'h0, 4'hF, 1'b1);
      if (cyc == t0 + PL + 2) begin
        checks++; if (res_valid !== 4'b0100 || res_data !== 32'h3e800000)
          begin errors++; $display("FAIL single_res got=%b/%h exp=0100/3e800000", res_valid, res_data); end
      end else begin
        checks++; if (res_valid !== 4'b0000)
          begin errors++; $display("FAIL single_res_idle cyc=%0d got=%b exp=0000", cyc - t0, res_valid); end
      end
    end
    checks++; if (issue_valid !== 1'b0 || issue_x0 !== 32'h3f800000 || issue_tag !== 2'd2)
      begin errors++; $display("FAIL single_hold got=%b/%h/%0d exp=0/3f800000/2", issue_valid, issue_x0, issue_tag); end
    checks++; if (res_data !== 32'h3e800000)
      begin errors++; $display("FAIL single_res_hold got=%h exp=3e800000", res_data); end
    force_pd = 1'b0;
  endtask

  task automatic test_cfg_mask();
    logic [N-1:0] seq [6];
    seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    assert_reset(4'h0, 4'b1011);
    release_reset(4'h0, 4'b1011);
    for (int k = 0; k < 6; k++) begin
      tick(4'hF, 4'b1011, 1'b1);
      checks++; if (req_ready !== seq[k] || req_ready[2] !== 1'b0)
        begin errors++; $display("FAIL mask_grant k=%0d got=%b exp=%b", k, req_ready, seq[k]); end
    end
    for (int k = 0; k < PL + 3; k++) begin
      tick(4'h0, 4'b1011, 1'b1);
      checks++; if (res_valid !== exp_rv || res_data !== exp_rd || res_valid[2] !== 1'b0)
        begin errors++; $display("FAIL mask_res got=%b/%h exp=%b/%h", res_valid, res_data, exp_rv, exp_rd); end
    end
  endtask

  task automatic test_orphan();
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    tick(4'h0, 4'hF, 1'b1);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL orphan_pre got=%b exp=0", err_sticky); end
    inject = 1'b1;
    tick(4'h0, 4'hF, 1'b1);
    inject = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(4'h0, 4'hF, 1'b1);
      checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL orphan_err k=%0d got=%b exp=1", k, err_sticky); end
      checks++; if (res_valid !== 4'b0) begin errors++; $display("FAIL orphan_res k=%0d got=%b exp=0", k, res_valid); end
    end
    assert_reset(4'h0, 4'hF);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL orphan_clear got=%b exp=0", err_sticky); end
    release_reset(4'h0, 4'hF);
  endtask

  task automatic test_reset_inflight();
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    for (int k = 0; k < 5; k++) tick(4'hF, 4'hF, 1'b1);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL inflight_issue got=%b exp=1", issue_valid); end
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    for (int k = 0; k < PL + 3; k++) begin
      tick(4'h0, 4'hF, 1'b1);
      checks++; if (res_valid !== 4'b0 || issue_valid !== 1'b0)
        begin errors++; $display("FAIL inflight_res k=%0d got=%b/%b exp=0/0", k, res_valid, issue_valid); end
    end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL inflight_err got=%b exp=0", err_sticky); end
  endtask

  task automatic test_random();
    logic [N-1:0] en, vld;
    assert_reset(4'h0, 4'hF);
    release_reset(4'h0, 4'hF);
    en = 4'hF;
    for (int k = 0; k < 400 + PL + 3; k++) begin
      if (k % 16 == 0) en = 4'($urandom_range(1, 15));
      vld = (k < 400) ? 4'($urandom) : 4'h0;
      tick(vld, en, 1'b1);
      checks++; if (req_ready !== exp_ready)
        begin errors++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
      checks++; if (issue_valid !== exp_iv || issue_tag !== exp_itag)
        begin errors++; $display("FAIL rnd_issue k=%0d got=%b/%0d exp=%b/%0d", k, issue_valid, issue_tag, exp_iv, exp_itag); end
      checks++; if (issue_x0 !== exp_ix0 || issue_x1 !== exp_ix1)
        begin errors++; $display("FAIL rnd_issue_data k=%0d got=%h/%h exp=%h/%h", k, issue_x0, issue_x1, exp_ix0, exp_ix1); end
      checks++; if (res_valid !== exp_rv || res_data !== exp_rd)
        begin errors++; $display("FAIL rnd_res k=%0d got=%b/%h exp=%b/%h", k, res_valid, res_data, exp_rv, exp_rd); end
      checks++; if (err_sticky !== exp_err)
        begin errors++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, err_sticky, exp_err); end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; m_ptr = 0;
    inject = 1'b0; force_pd = 1'b0; forced_pd = '0;
    rstn = 1'b0; cfg_en = '0; req_valid = '0; tb_x0 = '0; tb_x1 = '0;
    pipe_res_valid = 1'b0; pipe_res_data = '0;
    test_reset();
    test_round_robin();
    test_single_level();
    test_cfg_mask();
    test_orphan();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
